// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared helpers for the branch-history-table predictor.
//               Provides the counter reset value, saturating increment and
//               decrement, and the bimodal/gshare table-index hash. All
//               helpers work on a fixed 32-bit carrier. Callers cast the
//               result back to their own width.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int c_max_w = 32;

    // All-ones value of width w (1 <= w <= c_max_w), right-aligned.
    function automatic logic [c_max_w-1:0] ones(input int w);
        return {c_max_w{1'b1}} >> (c_max_w - w);
    endfunction

    // Weakly-not-taken reset value: 2^(w-1) - 1.
    function automatic logic [c_max_w-1:0] ctr_init(input int w);
        return ones(w) >> 1;
    endfunction

    // Increment that sticks at the all-ones value of width w.
    function automatic logic [c_max_w-1:0] sat_inc(input logic [c_max_w-1:0] v,
                                                   input int w);
        return (v >= ones(w)) ? ones(w) : v + c_max_w'(1);
    endfunction

    // Decrement that sticks at zero.
    function automatic logic [c_max_w-1:0] sat_dec(input logic [c_max_w-1:0] v);
        return (v == '0) ? '0 : v - c_max_w'(1);
    endfunction

    // Table index: the low idx_w PC bits, optionally XORed with the global
    // history. The history is narrower than the index, so it is implicitly
    // zero-extended by the carrier.
    function automatic logic [c_max_w-1:0] bp_index(input logic [c_max_w-1:0] pc,
                                                    input logic [c_max_w-1:0] ghr,
                                                    input bit                 gshare,
                                                    input int                 idx_w);
        return (gshare ? (pc ^ ghr) : pc) & ones(idx_w);
    endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_counter_table.sv
`default_nettype none
// ============================================================================
// Module      : bp_counter_table
// Description : 2^IDX_W x CTR_W saturating-counter array. It has LANES
//               combinational read ports, each returning the counter MSB
//               (predicted direction), and one saturating write port.
//               Async active-low reset loads every counter with the
//               weakly-not-taken value.
// Ports       : clk, reset (async, active-low)
//               rd_idx   [LANES*IDX_W] lane i index at [i*IDX_W +: IDX_W]
//               rd_taken [LANES]       MSB of the indexed counter
//               wr_en, wr_idx, wr_taken  saturating update towards taken/not
// Revision    : 1.0 - initial release
// ============================================================================
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CTR_W = 2,
    parameter int LANES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*IDX_W-1:0] rd_idx,
    output logic [LANES-1:0]       rd_taken,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic                   wr_taken
);

    localparam int               c_depth    = 1 << IDX_W;
    localparam logic [CTR_W-1:0] c_ctr_init = CTR_W'(ctr_init(CTR_W));

    logic [CTR_W-1:0] r_ctr [c_depth];
    logic [CTR_W-1:0] w_wr_next;

    assign w_wr_next = wr_taken ? CTR_W'(sat_inc(c_max_w'(r_ctr[wr_idx]), CTR_W))
                                : CTR_W'(sat_dec(c_max_w'(r_ctr[wr_idx])));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_ctr[i] <= c_ctr_init;
            end
        end else if (wr_en) begin
            r_ctr[wr_idx] <= w_wr_next;
        end
    end

    // Reads come from the array state before this edge's write lands, which
    // gives read-before-write for a lookup and update to the same index.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_rd
            assign rd_taken[i] = r_ctr[rd_idx[i*IDX_W +: IDX_W]][CTR_W-1];
        end
    endgenerate

endmodule : bp_counter_table
`default_nettype wire

// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_bht
// Description : Multi-lane branch-history-table predictor with an optional
//               gshare index. Fetch lookups return registered predictions
//               one cycle later. Execute resolves train the table and shift
//               the non-speculative global history. Saturating branch and
//               mispredict statistics are kept.
// Ports       : clk, reset (async, active-low)
//               lookup_valid_F/lookup_pc_F -> prediction_F, pred_valid_F, ghr_F
//               update_signal_E, update_pc_E, update_ghr_E,
//               actual_outcome_E, prediction_E
//               branch_count, mispredict_count
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int PC_W   = 5,
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2,
    parameter int GHR_W  = 4,
    parameter int GSHARE = 0,
    parameter int LANES  = 2,
    parameter int STAT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LANES-1:0]      lookup_valid_F,
    input  logic [LANES*PC_W-1:0] lookup_pc_F,
    output logic [LANES-1:0]      prediction_F,
    output logic [LANES-1:0]      pred_valid_F,
    output logic [GHR_W-1:0]      ghr_F,
    input  logic                  update_signal_E,
    input  logic [PC_W-1:0]       update_pc_E,
    input  logic [GHR_W-1:0]      update_ghr_E,
    input  logic                  actual_outcome_E,
    input  logic                  prediction_E,
    output logic [STAT_W-1:0]     branch_count,
    output logic [STAT_W-1:0]     mispredict_count
);

    localparam bit c_gshare = (GSHARE != 0);

    logic [GHR_W-1:0]       r_ghr;
    logic [GHR_W-1:0]       w_ghr_next;
    logic [LANES*IDX_W-1:0] w_rd_idx;
    logic [LANES-1:0]       w_rd_taken;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [LANES-1:0]       r_pred;
    logic [LANES-1:0]       r_valid;
    logic [GHR_W-1:0]       r_ghr_f;
    logic [STAT_W-1:0]      r_branch_cnt;
    logic [STAT_W-1:0]      r_mispred_cnt;

    // Lookups hash with the live GHR. Updates hash with the snapshot that
    // travelled down the pipe, so a branch trains the entry it was predicted from.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lookup_idx
            assign w_rd_idx[i*IDX_W +: IDX_W] =
                IDX_W'(bp_index(c_max_w'(lookup_pc_F[i*PC_W +: PC_W]),
                                c_max_w'(r_ghr), c_gshare, IDX_W));
        end
    endgenerate

    assign w_wr_idx = IDX_W'(bp_index(c_max_w'(update_pc_E), c_max_w'(update_ghr_E),
                                      c_gshare, IDX_W));

    generate
        if (GHR_W > 1) begin : g_ghr_shift
            assign w_ghr_next = {r_ghr[GHR_W-2:0], actual_outcome_E};
        end else begin : g_ghr_single
            assign w_ghr_next = actual_outcome_E;
        end
    endgenerate

    bp_counter_table #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W),
        .LANES (LANES)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (w_rd_idx),
        .rd_taken (w_rd_taken),
        .wr_en    (update_signal_E),
        .wr_idx   (w_wr_idx),
        .wr_taken (actual_outcome_E)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ghr         <= '0;
            r_pred        <= '0;
            r_valid       <= '0;
            r_ghr_f       <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_pred  <= w_rd_taken;
            r_valid <= lookup_valid_F;
            r_ghr_f <= r_ghr;   // pre-update history, aligned with r_pred
            if (update_signal_E) begin
                r_ghr        <= w_ghr_next;
                r_branch_cnt <= STAT_W'(sat_inc(c_max_w'(r_branch_cnt), STAT_W));
                if (actual_outcome_E != prediction_E) begin
                    r_mispred_cnt <= STAT_W'(sat_inc(c_max_w'(r_mispred_cnt), STAT_W));
                end
            end
        end
    end

    assign prediction_F     = r_pred;
    assign pred_valid_F     = r_valid;
    assign ghr_F            = r_ghr_f;
    assign branch_count     = r_branch_cnt;
    assign mispredict_count = r_mispred_cnt;

endmodule : branch_predictor_bht
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_bht
// Description : Self-checking bench. Drives a bimodal instance (16-bit stats)
//               and a gshare instance (3-bit stats, so stat saturation is
//               reachable) with the same stimulus. Both are compared against
//               an array-based reference model, first with directed
//               scenarios and then with random traffic and random async resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  lookup_valid_F = '0;
    logic [9:0]  lookup_pc_F = '0;
    logic        update_signal_E = 1'b0;
    logic [4:0]  update_pc_E = '0;
    logic [3:0]  update_ghr_E = '0;
    logic        actual_outcome_E = 1'b0;
    logic        prediction_E = 1'b0;

    logic [1:0]  pred_bi, valid_bi, pred_gs, valid_gs;
    logic [3:0]  ghr_bi, ghr_gs;
    logic [15:0] bc_bi, mc_bi;
    logic [2:0]  bc_gs, mc_gs;

    int total = 0;
    int bad   = 0;

    // Reference model state, one slot per instance (0 = bimodal, 1 = gshare)
    int tbl [2][16];
    int ghr [2];
    int bc [2];
    int mc [2];
    int stat_max [2] = '{65535, 7};
    int exp_pred [2][2];
    int exp_valid;
    int exp_ghr_f [2];

    always #5 clk = ~clk;

    branch_predictor_bht #(.GSHARE(0), .STAT_W(16)) dut_bi (
        .clk(clk), .reset(reset),
        .lookup_valid_F(lookup_valid_F), .lookup_pc_F(lookup_pc_F),
        .prediction_F(pred_bi), .pred_valid_F(valid_bi), .ghr_F(ghr_bi),
        .update_signal_E(update_signal_E), .update_pc_E(update_pc_E),
        .update_ghr_E(update_ghr_E), .actual_outcome_E(actual_outcome_E),
        .prediction_E(prediction_E),
        .branch_count(bc_bi), .mispredict_count(mc_bi)
    );

    branch_predictor_bht #(.GSHARE(1), .STAT_W(3)) dut_gs (
        .clk(clk), .reset(reset),
        .lookup_valid_F(lookup_valid_F), .lookup_pc_F(lookup_pc_F),
        .prediction_F(pred_gs), .pred_valid_F(valid_gs), .ghr_F(ghr_gs),
        .update_signal_E(update_signal_E), .update_pc_E(update_pc_E),
        .update_ghr_E(update_ghr_E), .actual_outcome_E(actual_outcome_E),
        .prediction_E(prediction_E),
        .branch_count(bc_gs), .mispredict_count(mc_gs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) tbl[m][i] = 1;
            ghr[m] = 0; bc[m] = 0; mc[m] = 0; exp_ghr_f[m] = 0;
            exp_pred[m][0] = 0; exp_pred[m][1] = 0;
        end
        exp_valid = 0;
    endtask

    // What one rising edge does, in terms of the predictor's rules.
    task automatic model_edge();
        int idx, pc;
        for (int m = 0; m < 2; m++) begin
            for (int l = 0; l < 2; l++) begin
                pc  = int'(lookup_pc_F[l*5 +: 5]);
                idx = (pc ^ (m == 1 ? ghr[m] : 0)) % 16;
                exp_pred[m][l] = (tbl[m][idx] >= 2) ? 1 : 0;
            end
            exp_ghr_f[m] = ghr[m];
        end
        exp_valid = int'(lookup_valid_F);
        if (update_signal_E) begin
            for (int m = 0; m < 2; m++) begin
                idx = (int'(update_pc_E) ^ (m == 1 ? int'(update_ghr_E) : 0)) % 16;
                if (actual_outcome_E) tbl[m][idx] = (tbl[m][idx] == 3) ? 3 : tbl[m][idx] + 1;
                else                  tbl[m][idx] = (tbl[m][idx] == 0) ? 0 : tbl[m][idx] - 1;
                ghr[m] = (ghr[m] * 2 + int'(actual_outcome_E)) % 16;
                if (bc[m] < stat_max[m]) bc[m]++;
                if (actual_outcome_E != prediction_E && mc[m] < stat_max[m]) mc[m]++;
            end
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, " bi valid"}, valid_bi, exp_valid);
        check({ph, " gs valid"}, valid_gs, exp_valid);
        check({ph, " bi ghr_F"}, ghr_bi, exp_ghr_f[0]);
        check({ph, " gs ghr_F"}, ghr_gs, exp_ghr_f[1]);
        check({ph, " bi branch_count"}, bc_bi, bc[0]);
        check({ph, " gs branch_count"}, bc_gs, bc[1]);
        check({ph, " bi mispredict_count"}, mc_bi, mc[0]);
        check({ph, " gs mispredict_count"}, mc_gs, mc[1]);
        for (int l = 0; l < 2; l++) begin
            if (exp_valid[l]) begin
                check($sformatf("%s bi pred lane%0d", ph, l), pred_bi[l], exp_pred[0][l]);
                check($sformatf("%s gs pred lane%0d", ph, l), pred_gs[l], exp_pred[1][l]);
            end
        end
    endtask

    task automatic cycle(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic drive(input logic [1:0] lv, input int pc0, input int pc1,
                         input logic upd, input int upc, input int ughr,
                         input logic act, input logic pe);
        lookup_valid_F   = lv;
        lookup_pc_F      = {5'(pc1), 5'(pc0)};
        update_signal_E  = upd;
        update_pc_E      = 5'(upc);
        update_ghr_E     = 4'(ughr);
        actual_outcome_E = act;
        prediction_E     = pe;
    endtask

    // Asserts reset between edges and checks outputs clear without a clock.
    task automatic async_reset(input string ph);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_all(ph);
        check({ph, " bi pred"}, pred_bi, 0);
        check({ph, " gs pred"}, pred_gs, 0);
        check({ph, " bi branch_count"}, bc_bi, 0);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #7;
        check_all("reset");
        check("reset pred", pred_bi, 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset state seen through a lookup
        drive(2'b01, 3, 0, 0, 0, 0, 0, 0);
        cycle("post-reset lookup");
        check("post-reset pc3 pred", pred_bi[0], 0);
        check("post-reset pc3 valid", valid_bi[0], 1);

        // Training on pc=3: 01 -> 10 -> 11 -> 10 -> 01
        drive(2'b00, 0, 0, 1, 3, 0, 1, 0); cycle("train t1");
        cycle("train t2");
        drive(2'b01, 3, 0, 0, 0, 0, 0, 0); cycle("train look");
        check("train 11 pred", pred_bi[0], 1);
        drive(2'b00, 0, 0, 1, 3, 0, 0, 1); cycle("train n1");
        drive(2'b01, 3, 0, 0, 0, 0, 0, 0); cycle("train look");
        check("train 10 pred", pred_bi[0], 1);
        drive(2'b00, 0, 0, 1, 3, 0, 0, 1); cycle("train n2");
        drive(2'b01, 3, 0, 0, 0, 0, 0, 0); cycle("train look");
        check("train 01 pred", pred_bi[0], 0);

        // Saturation on pc=7
        drive(2'b00, 0, 0, 1, 7, 0, 1, 1);
        for (int i = 0; i < 5; i++) cycle("sat up");
        drive(2'b01, 7, 0, 0, 0, 0, 0, 0); cycle("sat look");
        check("sat high pred", pred_bi[0], 1);
        drive(2'b00, 0, 0, 1, 7, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle("sat down");
        drive(2'b01, 7, 0, 0, 0, 0, 0, 0); cycle("sat look");
        check("sat low pred", pred_bi[0], 0);
        drive(2'b00, 0, 0, 1, 7, 0, 1, 0); cycle("sat one up");
        drive(2'b01, 7, 0, 0, 0, 0, 0, 0); cycle("sat look");
        check("sat no wrap pred", pred_bi[0], 0);

        // Same-edge collision on pc=3 (counter 01), both lanes on pc=3
        drive(2'b11, 3, 3, 1, 3, 0, 1, 0); cycle("collide");
        check("collide lane0 old value", pred_bi[0], 0);
        check("collide lane1 old value", pred_bi[1], 0);
        drive(2'b11, 3, 3, 0, 0, 0, 0, 0); cycle("collide next");
        check("collide lane0 new value", pred_bi[0], 1);
        check("collide lane1 new value", pred_bi[1], 1);

        // Mid-cycle async reset, then counter[3] must be back to 01
        async_reset("async reset 1");
        drive(2'b01, 3, 0, 0, 0, 0, 0, 0); cycle("after async");
        check("after async pc3 pred", pred_bi[0], 0);

        // Stats: three resolves, one mispredicted
        drive(2'b00, 0, 0, 1, 9, 0, 1, 1); cycle("stats 1");
        drive(2'b00, 0, 0, 1, 9, 0, 0, 1); cycle("stats 2");
        drive(2'b00, 0, 0, 1, 9, 0, 1, 1); cycle("stats 3");
        check("stats branch_count", bc_bi, 3);
        check("stats mispredict_count", mc_bi, 1);

        // gshare from GHR=0: two taken resolves at pc=3 with snapshot 0101
        async_reset("async reset 2");
        drive(2'b00, 0, 0, 1, 3, 5, 1, 1); cycle("gshare t1");
        cycle("gshare t2");
        drive(2'b01, 5, 0, 0, 0, 0, 0, 0); cycle("gshare look");
        check("gshare pc5 pred", pred_gs[0], 1);
        check("gshare ghr_F", ghr_gs, 4'b0011);

        // Random traffic with occasional async resets
        for (int n = 0; n < 600; n++) begin
            drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) async_reset("rand reset");
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_branch_predictor_bht
`default_nettype wire

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised branch-history-table predictor for the superscalar pipeline: generalises the single-lane predict/resolve path (prediction_E, actual_outcome_E, update_signal_E) to LANES fetch lookups per cycle, configurable table depth and counter width, and an optional gshare mode. It sits between fetch, which supplies PCs and receives registered predictions, and execute, which supplies resolved outcomes. It also keeps saturating branch and mispredict statistics for verification.

## Interface
- PC_W, 5, PC width (word-addressed)
- IDX_W, 4, table index width; table holds 2^IDX_W counters
- CTR_W, 2, saturating-counter width (≥1)
- GHR_W, 4, global-history width, GHR_W ≤ IDX_W
- GSHARE, 0, 0 = bimodal index, 1 = gshare index
- LANES, 2, parallel lookup ports
- STAT_W, 16, statistics-counter width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- lookup_valid_F  in  LANES  per-lane lookup request
- lookup_pc_F  in  LANES*PC_W  lane i PC at bits [i*PC_W +: PC_W]
- prediction_F  out  LANES  registered predicted direction (1 = taken)
- pred_valid_F  out  LANES  registered copy of lookup_valid_F
- ghr_F  out  GHR_W  registered GHR snapshot aligned with prediction_F
- update_signal_E  in  1  resolved branch present in execute
- update_pc_E  in  PC_W  PC of resolved branch
- update_ghr_E  in  GHR_W  GHR snapshot carried from fetch with that branch
- actual_outcome_E  in  1  resolved direction
- prediction_E  in  1  direction predicted for that branch
- branch_count  out  STAT_W  resolved branches seen
- mispredict_count  out  STAT_W  resolves with actual_outcome_E ≠ prediction_E

## Operation
- Lookup index: bimodal = pc[IDX_W-1:0]; gshare = pc[IDX_W-1:0] XOR zero-extended GHR (current GHR for lookups, update_ghr_E for updates).
- Prediction = MSB of indexed counter.
- Update (update_signal_E=1): taken → counter+1, saturating at 2^CTR_W−1; not-taken → counter−1, saturating at 0.
- GHR updated only at resolve (non-speculative): GHR ← {GHR[GHR_W-2:0], actual_outcome_E}. Maintained in both modes; only used for indexing when GSHARE=1.
- Stats: branch_count += 1 per update; mispredict_count += 1 when actual_outcome_E ≠ prediction_E; both saturate at all-ones, never wrap.
- Lookups with lookup_valid_F=0 still drive prediction_F (don't-care value) but pred_valid_F=0.
- Multiple lanes hitting the same index: each returns the same value; no conflict.

## Timing
- Reset (reset=0, async): every counter = 2^(CTR_W-1)−1 (weakly not-taken, 01 for CTR_W=2); GHR=0; prediction_F=0; pred_valid_F=0; ghr_F=0; both stats=0. Reset asserted mid-operation clears immediately, without waiting for clk.
- Lookup latency 1 cycle: PC sampled at edge N, prediction_F/pred_valid_F/ghr_F valid after edge N.
- Update written at the edge where update_signal_E=1. A lookup sampled at the same edge to the same index returns the pre-update value (read-before-write). Lookups at later edges see the new value.
- GHR shift and stats take effect at the same edge as the table write. ghr_F captured at that edge holds the pre-update GHR.
- One update per cycle; no backpressure; no handshake beyond valid bits.

## Structure
- Package bp_pkg: counter-init constant function, sat_inc/sat_dec functions, index-hash function (bimodal/gshare).
- Sub-module bp_counter_table: 2^IDX_W×CTR_W array, async-reset init, LANES read ports, one saturating write port.
- Top holds GHR, output registers and stats counters.

## Test plan
- Reset: release reset, lookup pc=3 lane0 → prediction_F[0]=0, pred_valid_F[0]=1; branch_count=0, mispredict_count=0.
- Training: two taken updates pc=3 → lookup gives 1 (counter 11); one not-taken → still 1 (10); second not-taken → 0 (01).
- Saturation: five taken updates pc=7 then lookup → 1; five not-taken then lookup → 0; a single taken then lookup → 0 (counter 01, not wrapped).
- Same-edge collision: counter[3]=01; taken update pc=3 and lookup pc=3 at the same edge → prediction_F=0; lookup at the next edge → 1. Lanes 0/1 both pc=3 → identical results.
- gshare (GSHARE=1, GHR=0): two taken updates pc=3 with update_ghr_E=4'b0101 (index 6) → GHR=4'b0011. Lookup pc=5 (5^3=6) → prediction 1, ghr_F=4'b0011.
- Stats and async reset: three updates, one with actual ≠ prediction_E → branch_count=3, mispredict_count=1. Drop reset between edges → all outputs 0 immediately, and counter[3] is back to 01.
